// File: rtl/axi4_mem_upsize_bridge.sv
// Narrow-to-wide AXI4 memory bridge: remaps addresses into a fixed DDR window,
// steers narrow beats onto wide byte lanes and restores upstream IDs on B and R.

module axi4_mem_upsize_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A push at full is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + PTR_W'(do_push);
        rd_d  = rd_q + PTR_W'(do_pop);
        cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

module axi4_mem_upsize_bridge #(
    parameter int                  S_DATA_W  = 64,
    parameter int                  M_DATA_W  = 128,
    parameter int                  S_ADDR_W  = 32,
    parameter int                  M_ADDR_W  = 49,
    parameter int                  WINDOW_W  = 28,
    parameter logic [M_ADDR_W-1:0] ADDR_BASE = 49'h1000_0000,
    parameter int                  S_ID_W    = 4,
    parameter int                  M_ID_W    = 6,
    parameter logic [M_ID_W-1:0]   DS_ID     = '0,
    parameter int                  MAX_OUT   = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  s_axi_aw_valid,
    output logic                  s_axi_aw_ready,
    input  logic [S_ID_W-1:0]     s_axi_aw_id,
    input  logic [S_ADDR_W-1:0]   s_axi_aw_addr,
    input  logic [7:0]            s_axi_aw_len,
    input  logic [2:0]            s_axi_aw_size,
    input  logic [1:0]            s_axi_aw_burst,
    input  logic                  s_axi_aw_lock,
    input  logic [3:0]            s_axi_aw_cache,
    input  logic [2:0]            s_axi_aw_prot,
    input  logic [3:0]            s_axi_aw_qos,

    input  logic                  s_axi_w_valid,
    output logic                  s_axi_w_ready,
    input  logic [S_DATA_W-1:0]   s_axi_w_data,
    input  logic [S_DATA_W/8-1:0] s_axi_w_strb,
    input  logic                  s_axi_w_last,

    output logic                  s_axi_b_valid,
    input  logic                  s_axi_b_ready,
    output logic [S_ID_W-1:0]     s_axi_b_id,
    output logic [1:0]            s_axi_b_resp,

    input  logic                  s_axi_ar_valid,
    output logic                  s_axi_ar_ready,
    input  logic [S_ID_W-1:0]     s_axi_ar_id,
    input  logic [S_ADDR_W-1:0]   s_axi_ar_addr,
    input  logic [7:0]            s_axi_ar_len,
    input  logic [2:0]            s_axi_ar_size,
    input  logic [1:0]            s_axi_ar_burst,
    input  logic                  s_axi_ar_lock,
    input  logic [3:0]            s_axi_ar_cache,
    input  logic [2:0]            s_axi_ar_prot,
    input  logic [3:0]            s_axi_ar_qos,

    output logic                  s_axi_r_valid,
    input  logic                  s_axi_r_ready,
    output logic [S_ID_W-1:0]     s_axi_r_id,
    output logic [S_DATA_W-1:0]   s_axi_r_data,
    output logic [1:0]            s_axi_r_resp,
    output logic                  s_axi_r_last,

    output logic                  m_axi_aw_valid,
    input  logic                  m_axi_aw_ready,
    output logic [M_ID_W-1:0]     m_axi_aw_id,
    output logic [M_ADDR_W-1:0]   m_axi_aw_addr,
    output logic [7:0]            m_axi_aw_len,
    output logic [2:0]            m_axi_aw_size,
    output logic [1:0]            m_axi_aw_burst,
    output logic                  m_axi_aw_lock,
    output logic [3:0]            m_axi_aw_cache,
    output logic [2:0]            m_axi_aw_prot,
    output logic [3:0]            m_axi_aw_qos,

    output logic                  m_axi_w_valid,
    input  logic                  m_axi_w_ready,
    output logic [M_DATA_W-1:0]   m_axi_w_data,
    output logic [M_DATA_W/8-1:0] m_axi_w_strb,
    output logic                  m_axi_w_last,

    input  logic                  m_axi_b_valid,
    output logic                  m_axi_b_ready,
    input  logic [M_ID_W-1:0]     m_axi_b_id,
    input  logic [1:0]            m_axi_b_resp,

    output logic                  m_axi_ar_valid,
    input  logic                  m_axi_ar_ready,
    output logic [M_ID_W-1:0]     m_axi_ar_id,
    output logic [M_ADDR_W-1:0]   m_axi_ar_addr,
    output logic [7:0]            m_axi_ar_len,
    output logic [2:0]            m_axi_ar_size,
    output logic [1:0]            m_axi_ar_burst,
    output logic                  m_axi_ar_lock,
    output logic [3:0]            m_axi_ar_cache,
    output logic [2:0]            m_axi_ar_prot,
    output logic [3:0]            m_axi_ar_qos,

    input  logic                  m_axi_r_valid,
    output logic                  m_axi_r_ready,
    input  logic [M_ID_W-1:0]     m_axi_r_id,
    input  logic [M_DATA_W-1:0]   m_axi_r_data,
    input  logic [1:0]            m_axi_r_resp,
    input  logic                  m_axi_r_last
);
    localparam int         S_STRB_W    = S_DATA_W / 8;
    localparam int         M_STRB_W    = M_DATA_W / 8;
    localparam int         OFF_W       = $clog2(M_STRB_W);
    localparam int         LANE_SH     = $clog2(S_STRB_W);
    localparam int         NLANE       = M_DATA_W / S_DATA_W;
    localparam int         DESC_W      = 3 + 2 + OFF_W;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    // Byte offset of the next beat within the wide bus; FIXED bursts stay put.
    function automatic logic [OFF_W-1:0] next_off(input logic [OFF_W-1:0] off,
                                                  input logic [2:0]       size,
                                                  input logic [1:0]       burst);
        logic [OFF_W-1:0] step;
        step = OFF_W'(1) << size;
        if (burst == BURST_FIXED) return off;
        return (off & ~(step - OFF_W'(1))) + step;
    endfunction

    logic                  live;
    logic                  aw_full, ar_full, aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                  wl_empty, wl_full, bid_empty, bid_full, rd_empty, rd_full;
    logic [DESC_W-1:0]     aw_desc, ar_desc, wl_dout;
    logic [S_ID_W-1:0]     bid_dout;
    logic [S_ID_W+DESC_W-1:0] rd_dout;
    logic [2:0]            wl_size, rd_size;
    logic [1:0]            wl_burst, rd_burst;
    logic [OFF_W-1:0]      wl_off, rd_off;
    logic [OFF_W-1:0]      woff_q, woff_d, roff_q, roff_d;
    logic                  wfirst_q, wfirst_d, rfirst_q, rfirst_d;
    logic [OFF_W-1:0]      cur_woff, cur_roff, wlane, rlane;
    logic                  unused_ok;

    // Every valid/ready output is forced low while reset is asserted.
    assign live = reset;

    assign aw_desc = {s_axi_aw_size, s_axi_aw_burst, s_axi_aw_addr[OFF_W-1:0]};
    assign ar_desc = {s_axi_ar_size, s_axi_ar_burst, s_axi_ar_addr[OFF_W-1:0]};

    assign aw_full        = wl_full | bid_full;
    assign m_axi_aw_valid = live & s_axi_aw_valid & ~aw_full;
    assign s_axi_aw_ready = live & m_axi_aw_ready & ~aw_full;
    assign aw_hs          = live & s_axi_aw_valid & m_axi_aw_ready & ~aw_full;
    assign m_axi_aw_id    = DS_ID;
    assign m_axi_aw_addr  = {ADDR_BASE[M_ADDR_W-1:WINDOW_W], s_axi_aw_addr[WINDOW_W-1:0]};
    assign m_axi_aw_len   = s_axi_aw_len;
    assign m_axi_aw_size  = s_axi_aw_size;
    assign m_axi_aw_burst = s_axi_aw_burst;
    assign m_axi_aw_lock  = s_axi_aw_lock;
    assign m_axi_aw_cache = s_axi_aw_cache;
    assign m_axi_aw_prot  = s_axi_aw_prot;
    assign m_axi_aw_qos   = s_axi_aw_qos;

    assign ar_full        = rd_full;
    assign m_axi_ar_valid = live & s_axi_ar_valid & ~ar_full;
    assign s_axi_ar_ready = live & m_axi_ar_ready & ~ar_full;
    assign ar_hs          = live & s_axi_ar_valid & m_axi_ar_ready & ~ar_full;
    assign m_axi_ar_id    = DS_ID;
    assign m_axi_ar_addr  = {ADDR_BASE[M_ADDR_W-1:WINDOW_W], s_axi_ar_addr[WINDOW_W-1:0]};
    assign m_axi_ar_len   = s_axi_ar_len;
    assign m_axi_ar_size  = s_axi_ar_size;
    assign m_axi_ar_burst = s_axi_ar_burst;
    assign m_axi_ar_lock  = s_axi_ar_lock;
    assign m_axi_ar_cache = s_axi_ar_cache;
    assign m_axi_ar_prot  = s_axi_ar_prot;
    assign m_axi_ar_qos   = s_axi_ar_qos;

    axi4_mem_upsize_bridge_fifo #(.WIDTH(DESC_W), .DEPTH(MAX_OUT)) u_wl_fifo (
        .clock(clock), .reset(reset), .push_i(aw_hs), .pop_i(w_hs & s_axi_w_last),
        .din_i(aw_desc), .dout_o(wl_dout), .empty_o(wl_empty), .full_o(wl_full));

    axi4_mem_upsize_bridge_fifo #(.WIDTH(S_ID_W), .DEPTH(MAX_OUT)) u_bid_fifo (
        .clock(clock), .reset(reset), .push_i(aw_hs), .pop_i(b_hs),
        .din_i(s_axi_aw_id), .dout_o(bid_dout), .empty_o(bid_empty), .full_o(bid_full));

    axi4_mem_upsize_bridge_fifo #(.WIDTH(S_ID_W + DESC_W), .DEPTH(MAX_OUT)) u_rd_fifo (
        .clock(clock), .reset(reset), .push_i(ar_hs), .pop_i(r_hs & m_axi_r_last),
        .din_i({s_axi_ar_id, ar_desc}), .dout_o(rd_dout), .empty_o(rd_empty), .full_o(rd_full));

    assign {wl_size, wl_burst, wl_off} = wl_dout;
    assign {rd_size, rd_burst, rd_off} = rd_dout[DESC_W-1:0];

    // First beat of a burst takes its offset straight from the FIFO head.
    assign cur_woff = wfirst_q ? wl_off : woff_q;
    assign cur_roff = rfirst_q ? rd_off : roff_q;
    assign wlane    = cur_woff >> LANE_SH;
    assign rlane    = cur_roff >> LANE_SH;

    assign m_axi_w_valid = live & s_axi_w_valid & ~wl_empty;
    assign s_axi_w_ready = live & m_axi_w_ready & ~wl_empty;
    assign w_hs          = live & s_axi_w_valid & m_axi_w_ready & ~wl_empty;
    assign m_axi_w_data  = {NLANE{s_axi_w_data}};
    assign m_axi_w_last  = s_axi_w_last;

    always_comb begin
        m_axi_w_strb = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (wlane == OFF_W'(i)) m_axi_w_strb[i*S_STRB_W +: S_STRB_W] = s_axi_w_strb;
        end
    end

    assign s_axi_b_valid = live & m_axi_b_valid;
    assign m_axi_b_ready = live & s_axi_b_ready;
    assign b_hs          = live & m_axi_b_valid & s_axi_b_ready;
    assign s_axi_b_id    = bid_dout;
    assign s_axi_b_resp  = m_axi_b_resp;

    assign s_axi_r_valid = live & m_axi_r_valid;
    assign m_axi_r_ready = live & s_axi_r_ready;
    assign r_hs          = live & m_axi_r_valid & s_axi_r_ready;
    assign s_axi_r_id    = rd_dout[S_ID_W+DESC_W-1:DESC_W];
    assign s_axi_r_resp  = m_axi_r_resp;
    assign s_axi_r_last  = m_axi_r_last;

    always_comb begin
        s_axi_r_data = m_axi_r_data[S_DATA_W-1:0];
        for (int i = 1; i < NLANE; i++) begin
            if (rlane == OFF_W'(i)) s_axi_r_data = m_axi_r_data[i*S_DATA_W +: S_DATA_W];
        end
    end

    always_comb begin
        woff_d   = woff_q;
        wfirst_d = wfirst_q;
        roff_d   = roff_q;
        rfirst_d = rfirst_q;
        if (w_hs) begin
            woff_d   = next_off(cur_woff, wl_size, wl_burst);
            wfirst_d = s_axi_w_last;
        end
        if (r_hs && !rd_empty) begin
            roff_d   = next_off(cur_roff, rd_size, rd_burst);
            rfirst_d = m_axi_r_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            woff_q   <= '0;
            wfirst_q <= 1'b1;
            roff_q   <= '0;
            rfirst_q <= 1'b1;
        end else begin
            woff_q   <= woff_d;
            wfirst_q <= wfirst_d;
            roff_q   <= roff_d;
            rfirst_q <= rfirst_d;
        end
    end

    // Downstream IDs are constant, so returned IDs carry no information.
    assign unused_ok = ^{m_axi_b_id, m_axi_r_id,
                         s_axi_aw_addr[S_ADDR_W-1:WINDOW_W], s_axi_ar_addr[S_ADDR_W-1:WINDOW_W]};

`ifndef SYNTHESIS
    a_b_outstanding: assert property (@(posedge clock) disable iff (!reset)
        m_axi_b_valid |-> !bid_empty);
    a_r_outstanding: assert property (@(posedge clock) disable iff (!reset)
        m_axi_r_valid |-> !rd_empty);
    a_aw_size: assert property (@(posedge clock) disable iff (!reset)
        aw_hs |-> (s_axi_aw_size <= 3'(LANE_SH)));
    a_ar_size: assert property (@(posedge clock) disable iff (!reset)
        ar_hs |-> (s_axi_ar_size <= 3'(LANE_SH)));
`endif
endmodule

// File: tb/tb_axi4_mem_upsize_bridge.sv
// Directed bench for axi4_mem_upsize_bridge: address remap, lane steering,
// ID restoration, outstanding limit, W-before-AW and mid-burst reset.

module tb_axi4_mem_upsize_bridge;
    logic         clock = 1'b0;
    logic         reset;

    logic         s_axi_aw_valid, s_axi_aw_ready;
    logic [3:0]   s_axi_aw_id;
    logic [31:0]  s_axi_aw_addr;
    logic [7:0]   s_axi_aw_len;
    logic [2:0]   s_axi_aw_size;
    logic [1:0]   s_axi_aw_burst;
    logic         s_axi_aw_lock;
    logic [3:0]   s_axi_aw_cache;
    logic [2:0]   s_axi_aw_prot;
    logic [3:0]   s_axi_aw_qos;
    logic         s_axi_w_valid, s_axi_w_ready;
    logic [63:0]  s_axi_w_data;
    logic [7:0]   s_axi_w_strb;
    logic         s_axi_w_last;
    logic         s_axi_b_valid, s_axi_b_ready;
    logic [3:0]   s_axi_b_id;
    logic [1:0]   s_axi_b_resp;
    logic         s_axi_ar_valid, s_axi_ar_ready;
    logic [3:0]   s_axi_ar_id;
    logic [31:0]  s_axi_ar_addr;
    logic [7:0]   s_axi_ar_len;
    logic [2:0]   s_axi_ar_size;
    logic [1:0]   s_axi_ar_burst;
    logic         s_axi_ar_lock;
    logic [3:0]   s_axi_ar_cache;
    logic [2:0]   s_axi_ar_prot;
    logic [3:0]   s_axi_ar_qos;
    logic         s_axi_r_valid, s_axi_r_ready;
    logic [3:0]   s_axi_r_id;
    logic [63:0]  s_axi_r_data;
    logic [1:0]   s_axi_r_resp;
    logic         s_axi_r_last;

    logic         m_axi_aw_valid, m_axi_aw_ready;
    logic [5:0]   m_axi_aw_id;
    logic [48:0]  m_axi_aw_addr;
    logic [7:0]   m_axi_aw_len;
    logic [2:0]   m_axi_aw_size;
    logic [1:0]   m_axi_aw_burst;
    logic         m_axi_aw_lock;
    logic [3:0]   m_axi_aw_cache;
    logic [2:0]   m_axi_aw_prot;
    logic [3:0]   m_axi_aw_qos;
    logic         m_axi_w_valid, m_axi_w_ready;
    logic [127:0] m_axi_w_data;
    logic [15:0]  m_axi_w_strb;
    logic         m_axi_w_last;
    logic         m_axi_b_valid, m_axi_b_ready;
    logic [5:0]   m_axi_b_id;
    logic [1:0]   m_axi_b_resp;
    logic         m_axi_ar_valid, m_axi_ar_ready;
    logic [5:0]   m_axi_ar_id;
    logic [48:0]  m_axi_ar_addr;
    logic [7:0]   m_axi_ar_len;
    logic [2:0]   m_axi_ar_size;
    logic [1:0]   m_axi_ar_burst;
    logic         m_axi_ar_lock;
    logic [3:0]   m_axi_ar_cache;
    logic [2:0]   m_axi_ar_prot;
    logic [3:0]   m_axi_ar_qos;
    logic         m_axi_r_valid, m_axi_r_ready;
    logic [5:0]   m_axi_r_id;
    logic [127:0] m_axi_r_data;
    logic [1:0]   m_axi_r_resp;
    logic         m_axi_r_last;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;

    always #5 clock = ~clock;

    axi4_mem_upsize_bridge dut (
        .clock(clock), .reset(reset),
        .s_axi_aw_valid(s_axi_aw_valid), .s_axi_aw_ready(s_axi_aw_ready), .s_axi_aw_id(s_axi_aw_id),
        .s_axi_aw_addr(s_axi_aw_addr), .s_axi_aw_len(s_axi_aw_len), .s_axi_aw_size(s_axi_aw_size),
        .s_axi_aw_burst(s_axi_aw_burst), .s_axi_aw_lock(s_axi_aw_lock), .s_axi_aw_cache(s_axi_aw_cache),
        .s_axi_aw_prot(s_axi_aw_prot), .s_axi_aw_qos(s_axi_aw_qos),
        .s_axi_w_valid(s_axi_w_valid), .s_axi_w_ready(s_axi_w_ready), .s_axi_w_data(s_axi_w_data),
        .s_axi_w_strb(s_axi_w_strb), .s_axi_w_last(s_axi_w_last),
        .s_axi_b_valid(s_axi_b_valid), .s_axi_b_ready(s_axi_b_ready), .s_axi_b_id(s_axi_b_id),
        .s_axi_b_resp(s_axi_b_resp),
        .s_axi_ar_valid(s_axi_ar_valid), .s_axi_ar_ready(s_axi_ar_ready), .s_axi_ar_id(s_axi_ar_id),
        .s_axi_ar_addr(s_axi_ar_addr), .s_axi_ar_len(s_axi_ar_len), .s_axi_ar_size(s_axi_ar_size),
        .s_axi_ar_burst(s_axi_ar_burst), .s_axi_ar_lock(s_axi_ar_lock), .s_axi_ar_cache(s_axi_ar_cache),
        .s_axi_ar_prot(s_axi_ar_prot), .s_axi_ar_qos(s_axi_ar_qos),
        .s_axi_r_valid(s_axi_r_valid), .s_axi_r_ready(s_axi_r_ready), .s_axi_r_id(s_axi_r_id),
        .s_axi_r_data(s_axi_r_data), .s_axi_r_resp(s_axi_r_resp), .s_axi_r_last(s_axi_r_last),
        .m_axi_aw_valid(m_axi_aw_valid), .m_axi_aw_ready(m_axi_aw_ready), .m_axi_aw_id(m_axi_aw_id),
        .m_axi_aw_addr(m_axi_aw_addr), .m_axi_aw_len(m_axi_aw_len), .m_axi_aw_size(m_axi_aw_size),
        .m_axi_aw_burst(m_axi_aw_burst), .m_axi_aw_lock(m_axi_aw_lock), .m_axi_aw_cache(m_axi_aw_cache),
        .m_axi_aw_prot(m_axi_aw_prot), .m_axi_aw_qos(m_axi_aw_qos),
        .m_axi_w_valid(m_axi_w_valid), .m_axi_w_ready(m_axi_w_ready), .m_axi_w_data(m_axi_w_data),
        .m_axi_w_strb(m_axi_w_strb), .m_axi_w_last(m_axi_w_last),
        .m_axi_b_valid(m_axi_b_valid), .m_axi_b_ready(m_axi_b_ready), .m_axi_b_id(m_axi_b_id),
        .m_axi_b_resp(m_axi_b_resp),
        .m_axi_ar_valid(m_axi_ar_valid), .m_axi_ar_ready(m_axi_ar_ready), .m_axi_ar_id(m_axi_ar_id),
        .m_axi_ar_addr(m_axi_ar_addr), .m_axi_ar_len(m_axi_ar_len), .m_axi_ar_size(m_axi_ar_size),
        .m_axi_ar_burst(m_axi_ar_burst), .m_axi_ar_lock(m_axi_ar_lock), .m_axi_ar_cache(m_axi_ar_cache),
        .m_axi_ar_prot(m_axi_ar_prot), .m_axi_ar_qos(m_axi_ar_qos),
        .m_axi_r_valid(m_axi_r_valid), .m_axi_r_ready(m_axi_r_ready), .m_axi_r_id(m_axi_r_id),
        .m_axi_r_data(m_axi_r_data), .m_axi_r_resp(m_axi_r_resp), .m_axi_r_last(m_axi_r_last)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        s_axi_aw_valid = 1'b1;
        s_axi_aw_id    = id;
        s_axi_aw_addr  = addr;
        s_axi_aw_len   = len;
        s_axi_aw_size  = 3'd3;
        s_axi_aw_burst = burst;
        tick();
        s_axi_aw_valid = 1'b0;
    endtask

    task automatic w_beat(input string tag, input logic [63:0] data, input logic last,
                          input logic [15:0] exp_strb);
        s_axi_w_valid = 1'b1;
        s_axi_w_data  = data;
        s_axi_w_strb  = 8'hFF;
        s_axi_w_last  = last;
        #1;
        chk(tag, {s_axi_w_ready, m_axi_w_valid, m_axi_w_last, m_axi_w_strb},
            {1'b1, 1'b1, last, exp_strb});
        tick();
        s_axi_w_valid = 1'b0;
    endtask

    task automatic b_resp(input string tag, input logic [3:0] exp_id);
        m_axi_b_valid = 1'b1;
        m_axi_b_resp  = 2'b10;
        #1;
        chk(tag, {s_axi_b_valid, s_axi_b_id, s_axi_b_resp}, {1'b1, exp_id, 2'b10});
        tick();
        m_axi_b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        s_axi_aw_valid = 1'b1; s_axi_aw_id = 4'd2; s_axi_aw_addr = 32'h8000_1040;
        s_axi_aw_len = 8'd0; s_axi_aw_size = 3'd3; s_axi_aw_burst = INCR; s_axi_aw_lock = 1'b0;
        s_axi_aw_cache = 4'h3; s_axi_aw_prot = 3'h2; s_axi_aw_qos = 4'h1;
        s_axi_w_valid = 1'b1; s_axi_w_data = '0; s_axi_w_strb = 8'hFF; s_axi_w_last = 1'b1;
        s_axi_b_ready = 1'b1;
        s_axi_ar_valid = 1'b1; s_axi_ar_id = 4'd0; s_axi_ar_addr = 32'h8000_0000;
        s_axi_ar_len = 8'd0; s_axi_ar_size = 3'd3; s_axi_ar_burst = INCR; s_axi_ar_lock = 1'b0;
        s_axi_ar_cache = 4'h0; s_axi_ar_prot = 3'h0; s_axi_ar_qos = 4'h0;
        s_axi_r_ready = 1'b1;
        m_axi_aw_ready = 1'b1; m_axi_w_ready = 1'b1; m_axi_ar_ready = 1'b1;
        m_axi_b_valid = 1'b1; m_axi_b_id = 6'd0; m_axi_b_resp = 2'b00;
        m_axi_r_valid = 1'b1; m_axi_r_id = 6'd0; m_axi_r_data = '0; m_axi_r_resp = 2'b00;
        m_axi_r_last = 1'b1;

        // Reset held with inputs active: every valid/ready output stays low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hs", {m_axi_aw_valid, s_axi_aw_ready, m_axi_w_valid, s_axi_w_ready,
                           s_axi_b_valid, m_axi_b_ready, m_axi_ar_valid, s_axi_ar_ready,
                           s_axi_r_valid, m_axi_r_ready}, '0);
        end

        reset = 1'b1;
        s_axi_w_valid = 1'b0; s_axi_ar_valid = 1'b0; m_axi_b_valid = 1'b0; m_axi_r_valid = 1'b0;
        #1;
        chk("aw_vr", {m_axi_aw_valid, s_axi_aw_ready}, 2'b11);
        chk("aw_addr", m_axi_aw_addr, 49'h1000_1040);
        chk("aw_id", m_axi_aw_id, 6'd0);
        chk("aw_pass", {m_axi_aw_len, m_axi_aw_size, m_axi_aw_burst, m_axi_aw_lock,
                        m_axi_aw_cache, m_axi_aw_prot, m_axi_aw_qos},
            {8'd0, 3'd3, 2'b01, 1'b0, 4'h3, 3'h2, 4'h1});
        tick();
        s_axi_aw_valid = 1'b0;
        s_axi_w_valid = 1'b1; s_axi_w_data = 64'h0123_4567_89AB_CDEF; s_axi_w_last = 1'b1;
        #1;
        chk("w_repl", m_axi_w_data, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        w_beat("w_first", 64'h0123_4567_89AB_CDEF, 1'b1, 16'h00FF);
        b_resp("b_first", 4'd2);

        // INCR len=3 starting at offset 8 alternates upper/lower lanes.
        aw_send(4'd3, 32'h8000_0008, 8'd3, INCR);
        w_beat("incr_b0", 64'h10, 1'b0, 16'hFF00);
        w_beat("incr_b1", 64'h11, 1'b0, 16'h00FF);
        w_beat("incr_b2", 64'h12, 1'b0, 16'hFF00);
        w_beat("incr_b3", 64'h13, 1'b1, 16'h00FF);
        b_resp("b_incr", 4'd3);

        // Two reads in order; each picks its own lane from the wide R data.
        s_axi_ar_valid = 1'b1; s_axi_ar_id = 4'd5; s_axi_ar_addr = 32'h8000_0000;
        #1;
        chk("ar_map", {s_axi_ar_ready, m_axi_ar_valid, m_axi_ar_id, m_axi_ar_addr},
            {1'b1, 1'b1, 6'd0, 49'h1000_0000});
        tick();
        s_axi_ar_id = 4'd9; s_axi_ar_addr = 32'h8000_0008;
        tick();
        s_axi_ar_valid = 1'b0;
        m_axi_r_valid = 1'b1; m_axi_r_last = 1'b1;
        m_axi_r_data = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        #1;
        chk("r0_ctl", {s_axi_r_valid, s_axi_r_id, s_axi_r_last}, {1'b1, 4'd5, 1'b1});
        chk("r0_data", s_axi_r_data, 64'h0F1E_2D3C_4B5A_6978);
        tick();
        chk("r1_ctl", {s_axi_r_valid, s_axi_r_id, s_axi_r_last}, {1'b1, 4'd9, 1'b1});
        chk("r1_data", s_axi_r_data, 64'hFEDC_BA98_7654_3210);
        tick();
        m_axi_r_valid = 1'b0;

        // Fill the outstanding-write budget without any B.
        for (int i = 0; i < 8; i++) begin
            aw_send(4'(i), 32'h8000_0000 + 32'(i * 8), 8'd0, INCR);
            w_beat("fill_w", 64'(i), 1'b1, (i % 2 == 0) ? 16'h00FF : 16'hFF00);
        end
        s_axi_aw_valid = 1'b1; s_axi_aw_id = 4'd8; s_axi_aw_addr = 32'h8000_0000;
        s_axi_aw_len = 8'd0; s_axi_aw_burst = INCR;
        #1;
        chk("full_block", {s_axi_aw_ready, m_axi_aw_valid}, 2'b00);
        m_axi_b_valid = 1'b1; m_axi_b_resp = 2'b00;
        #1;
        chk("full_pop_same", {s_axi_aw_ready, s_axi_b_id}, {1'b0, 4'd0});
        tick();
        chk("ready_rise", {s_axi_aw_ready, s_axi_b_id}, {1'b1, 4'd1});
        tick();
        m_axi_b_valid = 1'b0;
        s_axi_aw_id = 4'd9; s_axi_aw_addr = 32'h8000_0008;
        #1;
        chk("pushpop_cnt", s_axi_aw_ready, 1'b1);
        tick();
        chk("refull", s_axi_aw_ready, 1'b0);
        s_axi_aw_valid = 1'b0;
        w_beat("fill_w8", 64'h8, 1'b1, 16'h00FF);
        w_beat("fill_w9", 64'h9, 1'b1, 16'hFF00);
        for (int i = 2; i < 10; i++) b_resp("drain_b", 4'(i));

        // W presented ahead of its AW must wait for the AW handshake.
        s_axi_w_valid = 1'b1; s_axi_w_data = 64'hAB; s_axi_w_strb = 8'hFF; s_axi_w_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w_early", {s_axi_w_ready, m_axi_w_valid}, 2'b00);
            tick();
        end
        s_axi_aw_valid = 1'b1; s_axi_aw_id = 4'd6; s_axi_aw_addr = 32'h8000_0008;
        s_axi_aw_len = 8'd0; s_axi_aw_burst = INCR;
        #1;
        chk("w_at_aw", s_axi_w_ready, 1'b0);
        tick();
        s_axi_aw_valid = 1'b0;
        chk("w_late", {s_axi_w_ready, m_axi_w_valid, m_axi_w_strb}, {1'b1, 1'b1, 16'hFF00});
        tick();
        s_axi_w_valid = 1'b0;
        b_resp("b_late", 4'd6);

        // FIXED burst keeps the starting lane for every beat.
        aw_send(4'd7, 32'h8000_0008, 8'd1, FIXED);
        w_beat("fixed_b0", 64'h70, 1'b0, 16'hFF00);
        w_beat("fixed_b1", 64'h71, 1'b1, 16'hFF00);
        b_resp("b_fixed", 4'd7);

        // Reset in the middle of a write burst with a read outstanding.
        aw_send(4'd4, 32'h8000_0000, 8'd3, INCR);
        w_beat("mid_b0", 64'h40, 1'b0, 16'h00FF);
        s_axi_ar_valid = 1'b1; s_axi_ar_id = 4'd12; s_axi_ar_addr = 32'h8000_0000;
        tick();
        s_axi_ar_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        s_axi_w_valid = 1'b1; s_axi_w_last = 1'b1;
        #1;
        chk("post_rst_w", {s_axi_w_ready, m_axi_w_valid}, 2'b00);
        s_axi_w_valid = 1'b0;
        aw_send(4'd10, 32'h8000_0000, 8'd0, INCR);
        w_beat("post_rst_lane", 64'hA0, 1'b1, 16'h00FF);
        b_resp("post_rst_b", 4'd10);
        s_axi_ar_valid = 1'b1; s_axi_ar_id = 4'd3; s_axi_ar_addr = 32'h8000_0008;
        tick();
        s_axi_ar_valid = 1'b0;
        m_axi_r_valid = 1'b1; m_axi_r_last = 1'b1;
        m_axi_r_data = 128'h5555_6666_7777_8888_1111_2222_3333_4444;
        #1;
        chk("post_rst_r", {s_axi_r_id, s_axi_r_data}, {4'd3, 64'h5555_6666_7777_8888});
        tick();
        m_axi_r_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
